// File: rtl/glitcbus_slave.sv
// glitcbus_slave: GLITCBUS byte-phase responder turning GAD transfers into 32-bit local register reads/writes
// Ports: clk_i/rst_n_i (GCLK, sync active-low reset); gsel_b_i/grdwr_b_i/gad_i bus inputs;
//   gad_o/gad_oe_o read-data drive to external IOBUF; user_adr_o/user_dat_o/user_wr_o/user_rd_o/user_dat_i
//   local register port; abort_o watchdog/early-deselect pulse; state_o debug state.
module glitcbus_slave #(
  parameter int WDOG_MAX = 15,
  parameter int READ_LAT = 1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        gsel_b_i,
  input  logic        grdwr_b_i,
  input  logic [7:0]  gad_i,
  output logic [7:0]  gad_o,
  output logic        gad_oe_o,
  output logic [15:0] user_adr_o,
  output logic [31:0] user_dat_o,
  output logic        user_wr_o,
  output logic        user_rd_o,
  input  logic [31:0] user_dat_i,
  output logic        abort_o,
  output logic [3:0]  state_o
);
  typedef enum logic [3:0] {
    IDLE, ADRH, ADRL, WR_D3, WR_D2, WR_D1, WR_D0, WR_TAIL,
    RD_TA0, RD_TA1, RD_D3, RD_D2, RD_D1, RD_D0, WAIT_DESEL
  } state_t;
  localparam logic [7:0] WD_MAX = 8'(WDOG_MAX);
  state_t      state_q, state_d;
  logic [7:0]  gad_q, gad_d, wd_q, wd_d;
  logic        oe_q, oe_d, wr_q, wr_d, rd_q, rd_d, abort_q, abort_d, rw_q, rw_d;
  logic [15:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d, rdat_q, rdat_d, rword;
  logic        busy, early, desel, trip, ok, drive, lat_edge;
  always_comb begin
    busy  = state_q != IDLE;
    early = state_q inside {ADRH, ADRL, WR_D3, WR_D2, WR_D1, RD_TA0, RD_TA1, RD_D3, RD_D2, RD_D1};
    desel = early && gsel_b_i;
    trip  = busy && !gsel_b_i && wd_q == WD_MAX - 8'd1;
    ok    = busy && !gsel_b_i && !trip;
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = gsel_b_i ? IDLE : ADRH;
      ADRH:    state_d = ADRL;
      ADRL:    state_d = rw_q ? RD_TA0 : WR_D3;
      WR_D3:   state_d = WR_D2;
      WR_D2:   state_d = WR_D1;
      WR_D1:   state_d = WR_D0;
      WR_D0:   state_d = WR_TAIL;
      RD_TA0:  state_d = RD_TA1;
      RD_TA1:  state_d = RD_D3;
      RD_D3:   state_d = RD_D2;
      RD_D2:   state_d = RD_D1;
      RD_D1:   state_d = RD_D0;
      default: state_d = gsel_b_i ? IDLE : WAIT_DESEL;
    endcase
    if (desel) state_d = IDLE;
    if (trip) state_d = WAIT_DESEL;
    abort_d = desel || trip;
    rw_d  = (!busy && !gsel_b_i) ? grdwr_b_i : rw_q;
    adr_d = (!busy && !gsel_b_i) ? {gad_i, adr_q[7:0]} :
            (state_q == ADRH && ok) ? {adr_q[15:8], gad_i} : adr_q;
    // write data arrives MSB first, so a byte shift register assembles the word
    dat_d = (ok && ((state_q == ADRL && !rw_q) || state_q inside {WR_D3, WR_D2, WR_D1})) ?
            {dat_q[23:0], gad_i} : dat_q;
    wr_d  = ok && state_q == WR_D1;
    rd_d  = ok && state_q == ADRH && rw_q;
    lat_edge = (READ_LAT != 0) ? state_q == RD_TA0 : (state_q == ADRL && rw_q);
    rdat_d = lat_edge ? user_dat_i : rdat_q;
    // with one-clock latency the word arrives on the same edge its first byte is launched
    rword = (READ_LAT != 0 && state_q == RD_TA0) ? user_dat_i : rdat_q;
    drive = ok && state_q inside {RD_TA0, RD_TA1, RD_D3, RD_D2};
    oe_d  = drive;
    gad_d = !drive ? 8'h00 :
            state_q == RD_TA0 ? rword[31:24] :
            state_q == RD_TA1 ? rdat_q[23:16] :
            state_q == RD_D3  ? rdat_q[15:8] : rdat_q[7:0];
    // saturating so the watchdog fires only once per stuck select
    wd_d = !busy ? 8'd0 : (!gsel_b_i && wd_q != WD_MAX) ? wd_q + 8'd1 : wd_q;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      gad_q   <= '0;
      oe_q    <= 1'b0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      abort_q <= 1'b0;
      rw_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      rdat_q  <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      gad_q   <= gad_d;
      oe_q    <= oe_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      abort_q <= abort_d;
      rw_q    <= rw_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      rdat_q  <= rdat_d;
      wd_q    <= wd_d;
    end
  end
  assign gad_o      = gad_q;
  assign gad_oe_o   = oe_q;
  assign user_adr_o = adr_q;
  assign user_dat_o = dat_q;
  assign user_wr_o  = wr_q;
  assign user_rd_o  = rd_q;
  assign abort_o    = abort_q;
  assign state_o    = state_q;
endmodule

// File: tb/tb_glitcbus_slave.sv
// tb_glitcbus_slave: directed cycle-by-cycle bench for glitcbus_slave
module tb_glitcbus_slave;
  logic        clk = 1'b0, rst_n = 1'b0, gsel_b = 1'b1, grdwr_b = 1'b1;
  logic [7:0]  gad_in = 8'h00;
  logic [31:0] user_dat_in = 32'h0;
  logic [7:0]  gad_out;
  logic        gad_oe, user_wr, user_rd, abort;
  logic [15:0] user_adr;
  logic [31:0] user_dat;
  logic [3:0]  state;
  int vectors = 0, miss = 0;
  localparam logic [3:0] S_IDLE = 4'd0, S_WAIT = 4'd14;
  glitcbus_slave #(.WDOG_MAX(15), .READ_LAT(1)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .gsel_b_i(gsel_b), .grdwr_b_i(grdwr_b), .gad_i(gad_in),
    .gad_o(gad_out), .gad_oe_o(gad_oe), .user_adr_o(user_adr), .user_dat_o(user_dat),
    .user_wr_o(user_wr), .user_rd_o(user_rd), .user_dat_i(user_dat_in), .abort_o(abort),
    .state_o(state)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic g, input logic rw, input logic [7:0] b);
    gsel_b = g;
    grdwr_b = rw;
    gad_in = b;
    @(posedge clk);
    #1;
  endtask
  task automatic do_write(input logic [15:0] a, input logic [31:0] d);
    logic [7:0] by [7];
    by[0] = a[15:8]; by[1] = a[7:0]; by[2] = d[31:24]; by[3] = d[23:16];
    by[4] = d[15:8]; by[5] = d[7:0]; by[6] = 8'h77;
    for (int k = 0; k < 7; k++) begin
      step(1'b0, k != 0, by[k]);
      chk("wr_oe", 32'(gad_oe), 32'd0);
      chk("wr_strobe", 32'(user_wr), 32'(k == 5));
      chk("wr_rd_strobe", 32'(user_rd), 32'd0);
      chk("wr_abort", 32'(abort), 32'd0);
      if (k == 5) begin
        chk("wr_adr", 32'(user_adr), 32'(a));
        chk("wr_dat", user_dat, d);
      end
    end
    step(1'b1, 1'b1, 8'h00);
    chk("wr_end_state", 32'(state), 32'(S_IDLE));
    chk("wr_end_strobe", 32'(user_wr), 32'd0);
  endtask
  task automatic do_read(input logic [15:0] a, input logic [31:0] d, input int last_low, input int abort_at);
    logic [7:0] exp_gad;
    for (int k = 0; k <= last_low; k++) begin
      user_dat_in = (k == 3) ? d : 32'h0BAD0BAD;
      step(1'b0, k == 0, k == 0 ? a[15:8] : k == 1 ? a[7:0] : 8'h5A);
      chk("rd_strobe", 32'(user_rd), 32'(k == 1));
      chk("rd_wr_strobe", 32'(user_wr), 32'd0);
      chk("rd_oe", 32'(gad_oe), 32'(k >= 3 && k <= 6));
      chk("rd_abort", 32'(abort), 32'(k == abort_at));
      if (k == 1) chk("rd_adr", 32'(user_adr), 32'(a));
      if (k >= 3 && k <= 6) begin
        exp_gad = k == 3 ? d[31:24] : k == 4 ? d[23:16] : k == 5 ? d[15:8] : d[7:0];
        chk("rd_gad", 32'(gad_out), 32'(exp_gad));
      end
      if (k == abort_at) chk("rd_wdog_state", 32'(state), 32'(S_WAIT));
    end
    user_dat_in = 32'h0BAD0BAD;
    step(1'b1, 1'b1, 8'h00);
    chk("rd_end_state", 32'(state), 32'(S_IDLE));
    chk("rd_end_oe", 32'(gad_oe), 32'd0);
  endtask
  initial begin
    step(1'b1, 1'b1, 8'h00);
    step(1'b0, 1'b0, 8'h12);
    chk("rst_state", 32'(state), 32'(S_IDLE));
    chk("rst_oe", 32'(gad_oe), 32'd0);
    chk("rst_gad", 32'(gad_out), 32'd0);
    chk("rst_wr", 32'(user_wr), 32'd0);
    chk("rst_rd", 32'(user_rd), 32'd0);
    chk("rst_abort", 32'(abort), 32'd0);
    chk("rst_adr", 32'(user_adr), 32'd0);
    chk("rst_dat", user_dat, 32'd0);
    rst_n = 1'b1;
    step(1'b1, 1'b1, 8'h00);
    chk("idle_state", 32'(state), 32'(S_IDLE));
    do_write(16'h1234, 32'hDEADBEEF);
    do_read(16'h00A5, 32'hCAFEF00D, 7, -1);
    step(1'b0, 1'b0, 8'h12);
    step(1'b0, 1'b1, 8'h34);
    step(1'b0, 1'b1, 8'hDE);
    step(1'b1, 1'b1, 8'hAD);
    chk("desel_abort", 32'(abort), 32'd1);
    chk("desel_state", 32'(state), 32'(S_IDLE));
    chk("desel_wr", 32'(user_wr), 32'd0);
    step(1'b1, 1'b1, 8'hBE);
    chk("desel_abort_end", 32'(abort), 32'd0);
    chk("desel_wr_late", 32'(user_wr), 32'd0);
    do_write(16'hBEEF, 32'h01020304);
    do_read(16'h4321, 32'h89ABCDEF, 39, 15);
    for (int k = 0; k < 5; k++) begin
      user_dat_in = (k == 3) ? 32'h11223344 : 32'h0BAD0BAD;
      step(1'b0, k == 0, k == 0 ? 8'h0F : k == 1 ? 8'hF0 : 8'h00);
    end
    chk("pre_rst_oe", 32'(gad_oe), 32'd1);
    chk("pre_rst_gad", 32'(gad_out), 32'h22);
    rst_n = 1'b0;
    step(1'b0, 1'b0, 8'h00);
    chk("midrst_oe", 32'(gad_oe), 32'd0);
    chk("midrst_state", 32'(state), 32'(S_IDLE));
    chk("midrst_gad", 32'(gad_out), 32'd0);
    chk("midrst_adr", 32'(user_adr), 32'd0);
    rst_n = 1'b1;
    step(1'b1, 1'b1, 8'h00);
    do_write(16'h0001, 32'h00000000);
    do_read(16'h5555, 32'hA5A5A5A5, 7, -1);
    do_write(16'hFFFF, 32'h13579BDF);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end
endmodule
